// File: rtl/cic_pkg.sv
// Shared CIC definitions: stage count, rate limits, controller state encoding,
// rate clamp and the bitgain table (ceil(N*log2(decimation))).
// Used by the decimator controller and reusable by the shifter/interpolator side.
package cic_pkg;

  localparam int N          = 4;
  localparam int MAXBITGAIN = 28;
  localparam int MINRATE    = 3;
  localparam int MAXRATE    = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    FILL  = 2'd2,
    RUN   = 2'd3
  } state_t;

  // Clamp a rate register value (decimation minus one) into the legal range.
  function automatic logic [7:0] rate_clamp(input logic [7:0] r);
    if (r < 8'(MINRATE)) return 8'(MINRATE);
    if (r > 8'(MAXRATE)) return 8'(MAXRATE);
    return r;
  endfunction

  // Smallest k with 2^k >= dec^N, i.e. ceil(N*log2(dec)). Only meaningful for N=4
  // and dec <= 128, where dec^4 fits in 32 bits.
  function automatic logic [4:0] bitgain(input logic [7:0] dec);
    logic [31:0] p;
    logic [4:0]  g;
    p = 32'(dec) * 32'(dec) * 32'(dec) * 32'(dec);
    g = 5'(MAXBITGAIN);
    for (int k = MAXBITGAIN; k >= 0; k--)
      if (p <= (32'd1 << k)) g = 5'(k);
    return g;
  endfunction

endpackage

// File: rtl/cic_dec_ctrl_if.sv
// Control/status bundle between the register bank side (master) and the
// decimation controller (slave).
//   enable, rate, strobe_in                          : master -> controller
//   strobe_out, valid_out, clear_pipe, shift, busy   : controller -> master/datapath
interface cic_dec_ctrl_if;
  logic       enable;
  logic [7:0] rate;
  logic       strobe_in;
  logic       strobe_out;
  logic       valid_out;
  logic       clear_pipe;
  logic [4:0] shift;
  logic       busy;

  modport master (output enable, rate, strobe_in,
                  input  strobe_out, valid_out, clear_pipe, shift, busy);
  modport slave  (input  enable, rate, strobe_in,
                  output strobe_out, valid_out, clear_pipe, shift, busy);
endinterface

// File: rtl/cic_bitgain_lut.sv
// Combinational bitgain lookup: rate (decimation minus one, already clamped to
// MINRATE..MAXRATE) -> output shifter select.
//   rate : in  8  clamped rate register value
//   gain : out 5  ceil(N*log2(rate+1))
module cic_bitgain_lut
  import cic_pkg::*;
(
  input  logic [7:0] rate,
  output logic [4:0] gain
);
  // rate <= MAXRATE, so rate+1 never wraps.
  assign gain = bitgain(rate + 8'd1);
endmodule

// File: rtl/cic_dec_ctrl.sv
// Sequencer for one CIC decimation channel: owns the decimation counter,
// issues the integrator/comb clear on enable or rate change, suppresses the
// first N output strobes while the comb pipeline refills, and registers the
// output shifter select.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : enable/rate/strobe_in in; strobe_out/valid_out/clear_pipe/shift/busy out
module cic_dec_ctrl
  import cic_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  cic_dec_ctrl_if.slave bus
);

  localparam int FW = $clog2(N + 1);

  state_t          state;
  logic [7:0]      rate_r;
  logic [7:0]      cnt;
  logic [FW-1:0]   fill;
  logic [7:0]      rate_eff;
  logic [4:0]      gain;
  logic            fire;

  assign rate_eff = rate_clamp(bus.rate);

  cic_bitgain_lut u_lut (.rate(rate_eff), .gain(gain));

  // Terminal count on a qualified input; still evaluated on a cycle that leaves
  // FILL/RUN so a strobe already due goes out (with valid_out held low).
  assign fire = ((state == FILL) || (state == RUN)) && bus.strobe_in && (cnt == 8'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      bus.strobe_out <= 1'b0;
      bus.valid_out  <= 1'b0;
      bus.clear_pipe <= 1'b1;
      bus.shift      <= 5'(MAXBITGAIN);
      bus.busy       <= 1'b1;
      cnt            <= '0;
      fill           <= '0;
      rate_r         <= 8'(MINRATE);
    end else begin
      bus.strobe_out <= fire;
      bus.valid_out  <= 1'b0;
      case (state)
        IDLE: begin
          bus.clear_pipe <= 1'b1;
          bus.busy       <= 1'b1;
          if (bus.enable) state <= FLUSH;
        end
        FLUSH: begin
          // Single-cycle clear; strobe_in is ignored here.
          rate_r         <= rate_eff;
          bus.shift      <= gain;
          cnt            <= rate_eff;
          fill           <= '0;
          bus.clear_pipe <= 1'b0;
          bus.busy       <= 1'b1;
          state          <= FILL;
        end
        default: begin
          if (!bus.enable) begin
            state          <= IDLE;
            bus.clear_pipe <= 1'b1;
            bus.busy       <= 1'b1;
          end else if (rate_eff != rate_r) begin
            state          <= FLUSH;
            bus.clear_pipe <= 1'b1;
            bus.busy       <= 1'b1;
          end else begin
            bus.clear_pipe <= 1'b0;
            bus.busy       <= (state != RUN);
            if (bus.strobe_in) begin
              if (cnt == 8'd0) begin
                cnt           <= rate_r;
                bus.valid_out <= (state == RUN);
                if (state == FILL) begin
                  fill <= fill + 1'b1;
                  // The N-th suppressed strobe completes the refill.
                  if (fill == FW'(N - 1)) begin
                    state    <= RUN;
                    bus.busy <= 1'b0;
                  end
                end
              end else begin
                cnt <= cnt - 8'd1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
